// File: rtl/cond_exec_ctx_unit.sv
// Multi-context conditional-execution unit: per-context NZCV banks and
// predication windows that gate the decoder's PCSrc/RegWrite/MemWrite.
module cond_exec_ctx_unit #(
  parameter int NUM_CTX = 4,
  parameter int CNT_W   = 2,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic [CTX_W-1:0] ctx_i,
  input  logic [1:0]       op,
  input  logic [2:0]       Cond,
  input  logic [CNT_W-1:0] pred_len_i,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       flags_o,
  output logic             pred_active_o
);

  localparam logic [1:0]     OP_BRANCH = 2'b10;
  localparam logic [1:0]     OP_PRED   = 2'b11;
  localparam logic [CTX_W:0] CTX_LIMIT = (CTX_W+1)'(NUM_CTX);

  logic [3:0]       flags_q [NUM_CTX];
  logic [CNT_W-1:0] cnt_q   [NUM_CTX];
  logic [2:0]       wcond_q [NUM_CTX];

  logic             ctx_ok;
  logic [CTX_W-1:0] ctx_idx;
  logic [3:0]       cur_flags;
  logic [CNT_W-1:0] cur_cnt;
  logic [2:0]       cur_wcond;
  logic             is_pred;
  logic             is_branch;
  logic             win_open;
  logic             instr_ok;
  logic             win_ok;
  logic             cond_ex;
  logic             gate_en;
  logic             flag_ok;
  logic             upd;

  // Flags are {N,Z,C,V}; only eight codes exist, the last being "always".
  function automatic logic eval_cond(input logic [2:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      3'b000:  eval_cond = z;
      3'b001:  eval_cond = ~z;
      3'b010:  eval_cond = (n != v);
      3'b011:  eval_cond = (n == v);
      3'b100:  eval_cond = ~z & (n == v);
      3'b101:  eval_cond = z | (n != v);
      3'b110:  eval_cond = c;
      default: eval_cond = 1'b1;
    endcase
  endfunction

  // Out-of-range contexts are steered to bank 0 for reads but never qualify.
  always_comb begin
    ctx_ok    = ({1'b0, ctx_i} < CTX_LIMIT);
    ctx_idx   = ctx_ok ? ctx_i : '0;
    cur_flags = flags_q[ctx_idx];
    cur_cnt   = cnt_q[ctx_idx];
    cur_wcond = wcond_q[ctx_idx];
  end

  always_comb begin
    is_pred   = (op == OP_PRED);
    is_branch = (op == OP_BRANCH);
    win_open  = (cur_cnt != '0);
    instr_ok  = is_branch ? eval_cond(Cond, cur_flags) : 1'b1;
    win_ok    = win_open ? eval_cond(cur_wcond, cur_flags) : 1'b1;
    cond_ex   = valid_i & ctx_ok & instr_ok & win_ok;
    gate_en   = cond_ex & ~is_pred;
    // A PRED instruction is never itself squashed by an open window.
    flag_ok   = valid_i & ctx_ok & (is_pred | (instr_ok & win_ok));
    upd       = valid_i & ~stall_i & ctx_ok;
  end

  always_comb begin
    PCSrc         = PCS & gate_en;
    MemWrite      = MemW & gate_en;
    RegWrite      = RegW & gate_en & ~NoWrite;
    flags_o       = ctx_ok ? cur_flags : 4'b0000;
    pred_active_o = ctx_ok & win_open;
  end

  // Only the bank of the issuing context is touched; others hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        flags_q[i] <= 4'b0000;
        cnt_q[i]   <= '0;
        wcond_q[i] <= 3'b111;
      end
    end else if (upd) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (ctx_idx == CTX_W'(i)) begin
          if (is_pred) begin
            wcond_q[i] <= Cond;
            cnt_q[i]   <= pred_len_i;
          end else if (cnt_q[i] != '0) begin
            cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          end
          if (FlagW[1] & flag_ok) flags_q[i][3:2] <= ALUFlags[3:2];
          if (FlagW[0] & flag_ok) flags_q[i][1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_exec_ctx_unit.sv
// Directed bench for cond_exec_ctx_unit: flag banks, condition codes,
// predication windows, stall and asynchronous reset.
module tb_cond_exec_ctx_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic       stall_i;
  logic [1:0] ctx_i;
  logic [1:0] op;
  logic [2:0] Cond;
  logic [1:0] pred_len_i;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite;
  logic [3:0] flags_o;
  logic       pred_active_o;

  int checks = 0;
  int fails  = 0;

  cond_exec_ctx_unit #(.NUM_CTX(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i),
    .ctx_i(ctx_i), .op(op), .Cond(Cond), .pred_len_i(pred_len_i),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .flags_o(flags_o), .pred_active_o(pred_active_o)
  );

  always #5 clk = ~clk;

  // ctl packs {PCS, RegW, MemW, NoWrite}; inputs settle 1 time unit before checks.
  task automatic applyStimulus(input logic [1:0] c, input logic [1:0] o,
                               input logic [2:0] cd, input logic [1:0] len,
                               input logic [3:0] alu, input logic [1:0] fw,
                               input logic [3:0] ctl, input logic stl = 1'b0);
    valid_i    = 1'b1;
    stall_i    = stl;
    ctx_i      = c;
    op         = o;
    Cond       = cd;
    pred_len_i = len;
    ALUFlags   = alu;
    FlagW      = fw;
    {PCS, RegW, MemW, NoWrite} = ctl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    valid_i = 1'b0; stall_i = 1'b0; ctx_i = 2'd0; op = 2'b00; Cond = 3'b000;
    pred_len_i = 2'd0; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
    #1;
    $display("[TB] reset checks");
    checkOutput("rst_flags", flags_o, 4'h0);
    checkOutput("rst_pa", {3'b0, pred_active_o}, 4'h0);
    checkOutput("rst_gated", {1'b0, PCSrc, RegWrite, MemWrite}, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ctx0: write NZCV=0100, then EQ branch taken
    applyStimulus(2'd0, 2'b00, 3'b111, 2'd0, 4'b0100, 2'b11, 4'b0100);
    checkOutput("data_regwrite", {3'b0, RegWrite}, 4'h1);
    checkOutput("flags_before_edge", flags_o, 4'h0);
    tick();
    applyStimulus(2'd0, 2'b10, 3'b000, 2'd0, 4'h0, 2'b00, 4'b1000);
    checkOutput("flags_after_edge", flags_o, 4'b0100);
    checkOutput("beq_taken", {3'b0, PCSrc}, 4'h1);
    applyStimulus(2'd0, 2'b10, 3'b001, 2'd0, 4'h0, 2'b00, 4'b1000);
    checkOutput("bne_ctx0", {3'b0, PCSrc}, 4'h0);
    applyStimulus(2'd1, 2'b10, 3'b001, 2'd0, 4'h0, 2'b00, 4'b1000);
    checkOutput("bne_ctx1", {3'b0, PCSrc}, 4'h1);
    checkOutput("ctx1_flags", flags_o, 4'h0);
    applyStimulus(2'd0, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0101);
    checkOutput("nowrite", {3'b0, RegWrite}, 4'h0);
    applyStimulus(2'd0, 2'b01, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0010);
    checkOutput("memwrite", {3'b0, MemWrite}, 4'h1);
    tick();

    // ctx2: N=1,V=0 exercises the signed compares
    applyStimulus(2'd2, 2'b00, 3'b111, 2'd0, 4'b1000, 2'b11, 4'b0000);
    tick();
    applyStimulus(2'd2, 2'b10, 3'b010, 2'd0, 4'h0, 2'b00, 4'b1000);
    checkOutput("blt", {3'b0, PCSrc}, 4'h1);
    applyStimulus(2'd2, 2'b10, 3'b011, 2'd0, 4'h0, 2'b00, 4'b1000);
    checkOutput("bge", {3'b0, PCSrc}, 4'h0);
    applyStimulus(2'd2, 2'b10, 3'b100, 2'd0, 4'h0, 2'b00, 4'b1000);
    checkOutput("bgt", {3'b0, PCSrc}, 4'h0);
    applyStimulus(2'd2, 2'b10, 3'b101, 2'd0, 4'h0, 2'b00, 4'b1000);
    checkOutput("ble", {3'b0, PCSrc}, 4'h1);
    applyStimulus(2'd2, 2'b10, 3'b110, 2'd0, 4'h0, 2'b00, 4'b1000);
    checkOutput("bcs", {3'b0, PCSrc}, 4'h0);
    applyStimulus(2'd2, 2'b10, 3'b111, 2'd0, 4'h0, 2'b00, 4'b1000);
    checkOutput("bal", {3'b0, PCSrc}, 4'h1);

    // ctx1 (Z=0): PRED EQ len=2, three register writes
    $display("[TB] predication window");
    applyStimulus(2'd1, 2'b11, 3'b000, 2'd2, 4'h0, 2'b00, 4'b1110);
    checkOutput("pred_forced0", {1'b0, PCSrc, RegWrite, MemWrite}, 4'h0);
    checkOutput("pred_pa_before", {3'b0, pred_active_o}, 4'h0);
    tick();
    applyStimulus(2'd1, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("win1", {2'b0, RegWrite, pred_active_o}, 4'b0001);
    tick();
    applyStimulus(2'd1, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("win2", {2'b0, RegWrite, pred_active_o}, 4'b0001);
    tick();
    applyStimulus(2'd1, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("win3", {2'b0, RegWrite, pred_active_o}, 4'b0010);
    tick();

    // Same window, stall on the 2nd instruction
    applyStimulus(2'd1, 2'b11, 3'b000, 2'd2, 4'h0, 2'b00, 4'b0000);
    tick();
    applyStimulus(2'd1, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("stl_win1", {2'b0, RegWrite, pred_active_o}, 4'b0001);
    tick();
    applyStimulus(2'd1, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100, 1'b1);
    checkOutput("stl_win2_stalled", {2'b0, RegWrite, pred_active_o}, 4'b0001);
    tick();
    applyStimulus(2'd1, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("stl_win2_retry", {2'b0, RegWrite, pred_active_o}, 4'b0001);
    tick();
    applyStimulus(2'd1, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("stl_win3", {2'b0, RegWrite, pred_active_o}, 4'b0010);
    tick();

    // ctx3: PRED CS len=3, first member clears C
    $display("[TB] window with flag writes");
    applyStimulus(2'd3, 2'b00, 3'b111, 2'd0, 4'b0010, 2'b01, 4'b0000);
    tick();
    applyStimulus(2'd3, 2'b11, 3'b110, 2'd3, 4'h0, 2'b00, 4'b0000);
    checkOutput("ctx3_c_set", flags_o, 4'b0010);
    tick();
    applyStimulus(2'd3, 2'b00, 3'b111, 2'd0, 4'b0000, 2'b01, 4'b0100);
    checkOutput("fw_win1", {2'b0, RegWrite, pred_active_o}, 4'b0011);
    tick();
    applyStimulus(2'd3, 2'b00, 3'b111, 2'd0, 4'b0010, 2'b01, 4'b0100);
    checkOutput("fw_c_cleared", flags_o, 4'b0000);
    checkOutput("fw_win2", {2'b0, RegWrite, pred_active_o}, 4'b0001);
    tick();
    applyStimulus(2'd3, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("fw_squashed_no_flag", flags_o, 4'b0000);
    checkOutput("fw_win3", {2'b0, RegWrite, pred_active_o}, 4'b0001);
    tick();
    applyStimulus(2'd3, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("fw_closed", {2'b0, RegWrite, pred_active_o}, 4'b0010);

    // ctx2 window len=3, then async reset away from any edge
    $display("[TB] asynchronous reset mid-window");
    applyStimulus(2'd2, 2'b11, 3'b111, 2'd3, 4'h0, 2'b00, 4'b0000);
    tick();
    valid_i = 1'b0;
    #1;
    checkOutput("pre_rst", {pred_active_o, flags_o[3:1]}, 4'b1100);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_pa", {3'b0, pred_active_o}, 4'h0);
    checkOutput("async_rst_flags", flags_o, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ctx0 (Z=0): PRED EQ len=3 squashes, PRED len=0 closes it
    $display("[TB] window close");
    applyStimulus(2'd0, 2'b11, 3'b000, 2'd3, 4'h0, 2'b00, 4'b0000);
    tick();
    applyStimulus(2'd0, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("close_open", {2'b0, RegWrite, pred_active_o}, 4'b0001);
    tick();
    applyStimulus(2'd1, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("ctx1_unaffected", {2'b0, RegWrite, pred_active_o}, 4'b0010);
    tick();
    applyStimulus(2'd0, 2'b11, 3'b000, 2'd0, 4'h0, 2'b00, 4'b0000);
    checkOutput("close_pa_before", {3'b0, pred_active_o}, 4'h1);
    tick();
    applyStimulus(2'd0, 2'b00, 3'b111, 2'd0, 4'h0, 2'b00, 4'b0100);
    checkOutput("closed", {2'b0, RegWrite, pred_active_o}, 4'b0010);
    tick();

    valid_i = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
